// File: rtl/sbox_word_serializer.sv
// Byte-serial front end for a shared forward S-box: issues one word as four bytes, then reassembles SubWord.
// Optional macro SER_ROTWORD_EN adds rot_i, which applies RotWord to the accepted word before issue.
module sbox_word_serializer #(
    parameter int SBOX_LAT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
`ifdef SER_ROTWORD_EN
    input  logic        rot_i,
`endif
    output logic [7:0]  sbox_u_o,
    output logic        sbox_v_o,
    input  logic [7:0]  sbox_s_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  iss_q, iss_d;
    logic [1:0]  cap_q, cap_d;
    logic [31:0] word_in;
    logic        trk_tail;
    logic        capture;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

`ifdef SER_ROTWORD_EN
    assign word_in = rot_i ? {in_word[23:0], in_word[31:24]} : in_word;
`else
    assign word_in = in_word;
`endif

    // Byte index 3-k equals ~k for a 2-bit count, so byte 3 goes out first.
    assign sbox_v_o  = (state_q == ISSUE);
    assign sbox_u_o  = sbox_v_o ? bitrev8(word_q[{~iss_q, 3'b000} +: 8]) : 8'h00;
    assign in_ready  = reset_n && (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_word  = res_q;
    assign capture   = trk_tail && ((state_q == ISSUE) || (state_q == DRAIN));

    generate
        if (SBOX_LAT == 0) begin : g_comb
            assign trk_tail = sbox_v_o;
        end else begin : g_pipe
            logic [SBOX_LAT-1:0] trk_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) trk_q <= '0;
                else          trk_q <= (trk_q << 1) | SBOX_LAT'(sbox_v_o);
            end
            assign trk_tail = trk_q[SBOX_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        res_d   = res_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        if (capture) begin
            res_d[{~cap_q, 3'b000} +: 8] = bitrev8(sbox_s_i);
            cap_d = cap_q + 2'd1;
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = word_in;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                iss_d = iss_q + 2'd1;
                if (iss_q == 2'd3) state_d = (SBOX_LAT > 0) ? DRAIN : HOLD;
            end
            DRAIN: begin
                if (capture && (cap_q == 2'd3)) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            iss_q   <= 2'd0;
            cap_q   <= 2'd0;
            res_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
        end
    end

    // Issue word is only read while sbox_v_o gates it, so it needs no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule
